cardinal_nic: RTL and testbench

// - Responder end of the processor's NIC load/store path: the processor issues nicLd/nicSt as memory-style

---
 rtl/cardinal_nic_pkg.sv | 15 +
 rtl/cardinal_nic_channel_buf.sv | 45 ++++
 rtl/cardinal_nic.sv | 91 +++++++++
 tb/tb_cardinal_nic.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: register map, packet width and virtual-channel bit.
package cardinal_nic_pkg;

    localparam int unsigned NIC_DATA_W = 64;
    localparam int unsigned NIC_ADDR_W = 2;

    localparam logic [1:0] NIC_ADDR_ICB    = 2'b00;
    localparam logic [1:0] NIC_ADDR_ICB_ST = 2'b01;
    localparam logic [1:0] NIC_ADDR_OCB    = 2'b10;
    localparam logic [1:0] NIC_ADDR_OCB_ST = 2'b11;

    // Packet bit that names the virtual channel; bit 0 is the MSB.
    localparam int unsigned NIC_VC_BIT = 0;

endpackage

// File: rtl/cardinal_nic_channel_buf.sv
// One-entry channel buffer with a full flag. A load is accepted only while the buffer is empty,
// and a clear only has an effect while it is full.
module nic_channel_buf #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [0:DATA_W-1] load_data,
    input  logic              clear,
    output logic [0:DATA_W-1] data,
    output logic              full
);

    logic [0:DATA_W-1] data_q, data_d;
    logic              full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (full_q) begin
            // A load that collides with a clear is still dropped: full was seen at cycle start.
            if (clear) begin
                full_d = 1'b0;
            end
        end else if (load) begin
            data_d = load_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Responder for the processor's nicLd/nicSt path: register decode, registered load data, and the
// handshake glue to the ring router's local port around an input and an output channel buffer.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int unsigned DATA_W = NIC_DATA_W,
    parameter int unsigned ADDR_W = NIC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    logic              ld_en, st_en;
    logic              icb_load, icb_clear, icb_full;
    logic              ocb_load, ocb_clear, ocb_full;
    logic [0:DATA_W-1] icb_data, ocb_data;
    logic [0:DATA_W-1] d_out_q, d_out_d;

    assign ld_en = nicEn & ~nicWrEn;
    assign st_en = nicEn & nicWrEn;

    assign net_ri    = ~icb_full;
    assign icb_load  = net_si & net_ri;
    assign icb_clear = ld_en & (addr == ADDR_W'(NIC_ADDR_ICB));

    assign ocb_load  = st_en & (addr == ADDR_W'(NIC_ADDR_OCB));
    assign ocb_clear = net_so;

    // Only the VC matching the router's current polarity may leave this cycle.
    assign net_so = ~reset & ocb_full & net_ro & (ocb_data[NIC_VC_BIT] == net_polarity);
    assign net_do = ocb_data;

    nic_channel_buf #(
        .DATA_W (DATA_W)
    ) u_icb (
        .clk       (clk),
        .reset     (reset),
        .load      (icb_load),
        .load_data (net_di),
        .clear     (icb_clear),
        .data      (icb_data),
        .full      (icb_full)
    );

    nic_channel_buf #(
        .DATA_W (DATA_W)
    ) u_ocb (
        .clk       (clk),
        .reset     (reset),
        .load      (ocb_load),
        .load_data (d_in),
        .clear     (ocb_clear),
        .data      (ocb_data),
        .full      (ocb_full)
    );

    always_comb begin
        d_out_d = d_out_q;
        if (ld_en) begin
            unique case (addr)
                ADDR_W'(NIC_ADDR_ICB):    d_out_d = icb_data;
                ADDR_W'(NIC_ADDR_ICB_ST): d_out_d = DATA_W'(icb_full);
                ADDR_W'(NIC_ADDR_OCB_ST): d_out_d = DATA_W'(ocb_full);
                default:                  d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: loads and sends push expectations, monitors pop and compare.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [0:63] d_in, d_out, net_di, net_do;
    logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

    int checks = 0;
    int errors = 0;
    int so_pulses = 0;

    logic [63:0] ld_q[$];
    logic [63:0] so_q[$];
    logic        ld_seen = 1'b0;

    always #5 clk = ~clk;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Load response is visible in the cycle after the load edge.
    always @(posedge clk) ld_seen <= nicEn & ~nicWrEn & ~reset;

    always @(negedge clk) begin
        if (ld_seen) begin
            if (ld_q.size() == 0) chk("unexpected_load", 64'd1, 64'd0);
            else chk("d_out", d_out, ld_q.pop_front());
        end
        if (net_so) begin
            so_pulses++;
            if (so_q.size() == 0) chk("unexpected_net_so", {32'd0, net_do[0:31]}, 64'd0);
            else chk("net_do", net_do, so_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [63:0] exp);
        ld_q.push_back(exp);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] a, input logic [63:0] data);
        addr = a; d_in = data; nicEn = 1'b1; nicWrEn = 1'b1;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 0; nicWrEn = 0;
        net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("reset_net_ri", {63'd0, net_ri}, 64'd1);
        chk("reset_net_so", {63'd0, net_so}, 64'd0);
        chk("reset_d_out", d_out, 64'd0);
        chk("reset_net_do", net_do, 64'd0);
        do_load(2'b01, 64'd0);
        do_load(2'b11, 64'd0);

        // Router -> ICB, then drain
        net_si = 1'b1; net_di = 64'h0123_4567_89AB_CDEF;
        tick();
        net_si = 1'b0;
        chk("icb_full_ri", {63'd0, net_ri}, 64'd0);
        do_load(2'b01, 64'd1);
        do_load(2'b00, 64'h0123_4567_89AB_CDEF);
        chk("icb_drained_ri", {63'd0, net_ri}, 64'd1);

        // Empty ICB read returns stale data; stores to 00 and un-enabled writes are ignored
        do_load(2'b00, 64'h0123_4567_89AB_CDEF);
        chk("empty_read_ri", {63'd0, net_ri}, 64'd1);
        do_store(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
        do_load(2'b01, 64'd0);
        do_load(2'b00, 64'h0123_4567_89AB_CDEF);
        addr = 2'b10; d_in = 64'h8000_0000_0000_1111; nicWrEn = 1'b1;
        tick();
        nicWrEn = 1'b0;
        do_load(2'b11, 64'd0);
        do_load(2'b10, 64'd0);

        // OCB send gated by polarity
        net_ro = 1'b1; net_polarity = 1'b0;
        do_store(2'b10, 64'h8000_0000_0000_0055);
        chk("pol_mismatch_so", {63'd0, net_so}, 64'd0);
        tick();
        chk("pol_mismatch_so2", {63'd0, net_so}, 64'd0);
        do_load(2'b11, 64'd1);
        so_q.push_back(64'h8000_0000_0000_0055);
        net_polarity = 1'b1;
        tick();
        chk("sent_so_low", {63'd0, net_so}, 64'd0);
        do_load(2'b11, 64'd0);

        // Store to full OCB dropped while router is busy
        net_ro = 1'b0;
        do_store(2'b10, 64'h8000_0000_0000_0077);
        do_store(2'b10, 64'h0000_0000_0000_DEAD);
        do_load(2'b11, 64'd1);
        chk("ro_low_so", {63'd0, net_so}, 64'd0);
        so_q.push_back(64'h8000_0000_0000_0077);
        net_ro = 1'b1;
        tick(); tick(); tick();
        chk("so_pulse_count", 64'(so_pulses), 64'd2);

        // Fill both buffers then reset
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'hAAAA_0000_0000_AAAA;
        tick();
        net_si = 1'b0;
        do_store(2'b10, 64'h8000_0000_0000_0099);
        do_load(2'b01, 64'd1);
        chk("prereset_d_out", d_out, 64'd1);
        reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
        #3;
        chk("reset_cycle_so", {63'd0, net_so}, 64'd0);
        tick();
        reset = 1'b0; net_ro = 1'b0;
        chk("post_reset_ri", {63'd0, net_ri}, 64'd1);
        chk("post_reset_so", {63'd0, net_so}, 64'd0);
        chk("post_reset_d_out", d_out, 64'd0);
        do_load(2'b01, 64'd0);
        do_load(2'b11, 64'd0);
        tick();

        chk("ld_q_drained", 64'(ld_q.size()), 64'd0);
        chk("so_q_drained", 64'(so_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
